// File: rtl/root_req_sequencer.sv
// root_req_sequencer: FIFO-buffered request feeder for the nth-root unit; one request in flight at a time.
// Optional WAIT timeout with stale-result drop is enabled by defining ROOT_SEQ_TIMEOUT_EN.
module root_req_sequencer #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYC    = 2
`ifdef ROOT_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1023
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  req_radicand,
   input  logic [2:0]  req_degree,
   output logic        root_in_valid,
   output logic [9:0]  root_in_data_1,
   output logic [2:0]  root_in_data_2,
   input  logic        root_out_valid,
   input  logic [19:0] root_out_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [19:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

   // Handshakes: a transfer happens on a rising edge where valid && ready; a source never
   // drops valid or changes its payload while valid && !ready.

   logic [9:0]  mem_rad [DEPTH];
   logic [2:0]  mem_deg [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty, push, pop, issue_ok;
   logic [9:0]  head_rad;
   logic [2:0]  head_deg;

   state_t      state, state_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic        riv_n, rv_n, re_n;
   logic [9:0]  d1_n;
   logic [2:0]  d2_n;
   logic [19:0] rd_n;

`ifdef ROOT_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          stale, stale_n;
`endif

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head_rad  = mem_rad[rd_ptr[AW-1:0]];
   assign head_deg  = mem_deg[rd_ptr[AW-1:0]];
   assign busy      = !empty || (state != IDLE);

`ifdef ROOT_SEQ_TIMEOUT_EN
   assign issue_ok = !empty && !root_out_valid && !stale;
`else
   assign issue_ok = !empty && !root_out_valid;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rad[wr_ptr[AW-1:0]] <= req_radicand;
         mem_deg[wr_ptr[AW-1:0]] <= req_degree;
      end
   end

   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      riv_n   = root_in_valid;
      d1_n    = root_in_data_1;
      d2_n    = root_in_data_2;
      rv_n    = rsp_valid;
      rd_n    = rsp_data;
      re_n    = rsp_err;
      pop     = 1'b0;
`ifdef ROOT_SEQ_TIMEOUT_EN
      tmo_n   = tmo_cnt;
      stale_n = stale;
      // The first result after a timeout belongs to the abandoned request.
      if (stale && root_out_valid) stale_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (issue_ok) begin
               pop = 1'b1;
               if (head_deg == 3'd0) begin
                  rv_n    = 1'b1;
                  re_n    = 1'b1;
                  rd_n    = 20'h0;
                  state_n = RESP;
               end else begin
                  d1_n    = head_rad;
                  d2_n    = head_deg;
                  riv_n   = 1'b1;
                  hold_n  = HW'(HOLD_CYC - 1);
                  state_n = DRIVE;
               end
            end
         end
         DRIVE: begin
            if (hold_cnt == '0) begin
               riv_n   = 1'b0;
               state_n = WAIT;
`ifdef ROOT_SEQ_TIMEOUT_EN
               tmo_n   = '0;
`endif
            end else begin
               hold_n = hold_cnt - HW'(1);
            end
         end
         WAIT: begin
            if (root_out_valid) begin
               rd_n    = root_out_data;
               re_n    = 1'b0;
               rv_n    = 1'b1;
               state_n = RESP;
            end
`ifdef ROOT_SEQ_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
               rd_n    = 20'h0;
               re_n    = 1'b1;
               rv_n    = 1'b1;
               stale_n = 1'b1;
               state_n = RESP;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rv_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         state          <= IDLE;
         hold_cnt       <= '0;
         root_in_valid  <= 1'b0;
         root_in_data_1 <= 10'h0;
         root_in_data_2 <= 3'h0;
         rsp_valid      <= 1'b0;
         rsp_data       <= 20'h0;
         rsp_err        <= 1'b0;
`ifdef ROOT_SEQ_TIMEOUT_EN
         tmo_cnt        <= '0;
         stale          <= 1'b0;
`endif
      end else begin
         wr_ptr         <= wr_ptr + (AW+1)'(push);
         rd_ptr         <= rd_ptr + (AW+1)'(pop);
         state          <= state_n;
         hold_cnt       <= hold_n;
         root_in_valid  <= riv_n;
         root_in_data_1 <= d1_n;
         root_in_data_2 <= d2_n;
         rsp_valid      <= rv_n;
         rsp_data       <= rd_n;
         rsp_err        <= re_n;
`ifdef ROOT_SEQ_TIMEOUT_EN
         tmo_cnt        <= tmo_n;
         stale          <= stale_n;
`endif
      end
   end

endmodule

// File: tb/tb_root_req_sequencer.sv
// Bench for root_req_sequencer: directed scenarios plus randomized traffic against a queue-based
// response model and a behavioural nth-root unit.
module tb_root_req_sequencer;

   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_radicand;
   logic [2:0]  req_degree;
   logic        root_in_valid;
   logic [9:0]  root_in_data_1;
   logic [2:0]  root_in_data_2;
   logic        root_out_valid;
   logic [19:0] root_out_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [19:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [20:0] exp_q[$];
   int          root_mode = 0;
   int          root_lat  = 1;
   logic        late_tog  = 1'b0;
   logic        rand_ready = 1'b0;
   int          seen_i, w_i, got_i;
   logic [19:0] got_data;

   root_req_sequencer #(
      .DEPTH(4),
      .HOLD_CYC(HOLD)
`ifdef ROOT_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_radicand(req_radicand), .req_degree(req_degree),
      .root_in_valid(root_in_valid), .root_in_data_1(root_in_data_1), .root_in_data_2(root_in_data_2),
      .root_out_valid(root_out_valid), .root_out_data(root_out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- reference functions ----------------
   function automatic logic [19:0] root_fn(input logic [9:0] r, input logic [2:0] d);
      real v;
      v = $pow(real'(r), 1.0 / real'(d)) * 1024.0;
      return 20'($rtoi(v));
   endfunction

   function automatic logic [20:0] exp_of(input logic [9:0] r, input logic [2:0] d);
      if (d == 3'd0) return {1'b1, 20'h0};
      return {1'b0, root_fn(r, d)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic offer(input logic [9:0] rad, input logic [2:0] deg);
      logic ok;
      ok = 1'b0;
      req_valid = 1'b1; req_radicand = rad; req_degree = deg;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            exp_q.push_back(exp_of(rad, deg));
         end
         step();
      end
      req_valid = 1'b0;
      chk("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic single_req(input logic [9:0] rad, input logic [2:0] deg, output logic [19:0] got);
      int hi, rov_at, rsp_at;
      hi = 0; rov_at = -1; rsp_at = -1;
      offer(rad, deg);
      for (int i = 0; i < 40; i++) begin
         step();
         if (root_in_valid) begin
            hi++;
            chk("drive_rad", 32'(root_in_data_1), 32'(rad));
            chk("drive_deg", 32'(root_in_data_2), 32'(deg));
         end
         if (root_out_valid && rov_at < 0) rov_at = i;
         if (rsp_valid) begin rsp_at = i; break; end
      end
      chk("rsp_seen", 32'(rsp_valid), 32'd1);
      chk("hold_cycles", 32'(hi), 32'(HOLD));
      chk("rsp_latency", 32'(rsp_at), 32'(rov_at));
      chk("rsp_err_ok", 32'(rsp_err), 32'd0);
      chk("rsp_data", 32'(rsp_data), 32'(root_fn(rad, deg)));
      got = rsp_data;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
      step();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- behavioural root unit ----------------
   initial begin : root_model
      logic       pending, late_seen;
      int         cnt;
      logic [9:0] r;
      logic [2:0] d;
      pending = 1'b0; late_seen = 1'b0; cnt = 0; r = '0; d = '0;
      root_out_valid = 1'b0;
      root_out_data  = 20'h0;
      forever begin
         @(posedge clk);
         #2;
         root_out_valid = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else if (late_tog != late_seen) begin
            late_seen      = late_tog;
            pending        = 1'b0;
            root_out_valid = 1'b1;
            root_out_data  = 20'hABCDE;
         end else if (root_in_valid) begin
            pending = 1'b1; r = root_in_data_1; d = root_in_data_2; cnt = root_lat;
         end else if (pending) begin
            if (cnt != 0) cnt--;
            else if (root_mode == 1) begin
               root_out_valid = 1'b1;
               root_out_data  = root_fn(r, d);
               pending        = 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   initial begin : rsp_mon
      logic        held;
      logic [20:0] held_v;
      held = 1'b0; held_v = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
               chk("rsp_hold_payload", 32'({rsp_err, rsp_data}), 32'(held_v));
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
               else chk("rsp_order", 32'({rsp_err, rsp_data}), 32'(exp_q.pop_front()));
            end
            held   = rsp_valid && !rsp_ready;
            held_v = {rsp_err, rsp_data};
         end
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_radicand = '0; req_degree = '0; rsp_ready = 1'b0;
      repeat (3) step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_root_in_valid", 32'(root_in_valid), 32'd0);
      chk("rst_data_1", 32'(root_in_data_1), 32'd0);
      chk("rst_data_2", 32'(root_in_data_2), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp", 32'({rsp_err, rsp_data}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();

      // basic request with the known result 4.0
      root_mode = 1; root_lat = 1;
      single_req(10'd16, 3'd2, got_data);
      chk("t1_data", 32'(got_data), 32'h01000);
      chk("t1_idle", 32'(busy), 32'd0);

      // degree 0 is answered locally with an error
      offer(10'd7, 3'd0);
      seen_i = 0; got_i = 0;
      for (int i = 0; i < 10; i++) begin
         if (root_in_valid) seen_i = 1;
         if (rsp_valid) begin got_i = 1; break; end
         step();
      end
      chk("t3_rsp", 32'(got_i), 32'd1);
      chk("t3_err", 32'(rsp_err), 32'd1);
      chk("t3_data", 32'(rsp_data), 32'd0);
      chk("t3_no_drive", 32'(seen_i), 32'd0);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      root_lat = 3;
      single_req(10'd81, 3'd4, got_data);

      // fill the FIFO behind a stalled root, then release
      root_mode = 0; root_lat = 0; rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++)
         offer(10'($urandom_range(0, 1023)), 3'($urandom_range(1, 7)));
      chk("t2_full", 32'(req_ready), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      root_mode = 1;
      drain("t2_drain");
      chk("t2_ready_back", 32'(req_ready), 32'd1);
      chk("t2_idle", 32'(busy), 32'd0);
      rsp_ready = 1'b0;

      // consumer back-pressure holds the response and blocks the next issue
      root_lat = 2;
      offer(10'd500, 3'd3);
      offer(10'd27, 3'd3);
      for (int i = 0; i < 50 && !rsp_valid; i++) step();
      for (int i = 0; i < 10; i++) begin
         chk("t4_valid", 32'(rsp_valid), 32'd1);
         chk("t4_payload", 32'({rsp_err, rsp_data}), 32'(exp_q[0]));
         chk("t4_no_issue", 32'(root_in_valid), 32'd0);
         step();
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      seen_i = 0;
      for (int i = 0; i < 10 && seen_i == 0; i++) begin
         step();
         if (root_in_valid) seen_i = 1;
      end
      chk("t4_next_issue", 32'(seen_i), 32'd1);
      rsp_ready = 1'b1;
      drain("t4_drain");
      rsp_ready = 1'b0;

      // asynchronous reset in the middle of DRIVE
      offer(10'd100, 3'd3);
      step();
      chk("t5_driving", 32'(root_in_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_riv", 32'(root_in_valid), 32'd0);
      chk("t5_ready", 32'(req_ready), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      exp_q.delete();
      step(); step();
      rst_n = 1'b1;
      seen_i = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp_valid || root_in_valid) seen_i = 1;
      end
      chk("t5_no_stale", 32'(seen_i), 32'd0);
      single_req(10'd343, 3'd3, got_data);

`ifdef ROOT_SEQ_TIMEOUT_EN
      // timeout, then the late result is dropped before the next issue
      root_mode = 0;
      offer(10'd200, 3'd5);
      void'(exp_q.pop_back());
      exp_q.push_back({1'b1, 20'h0});
      seen_i = 0; w_i = 0; got_i = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (root_in_valid) seen_i = 1;
         else if (seen_i == 1 && !rsp_valid) w_i++;
         if (rsp_valid) begin got_i = 1; break; end
      end
      chk("t6_rsp", 32'(got_i), 32'd1);
      chk("t6_wait_cycles", 32'(w_i), 32'd8);
      chk("t6_err", 32'(rsp_err), 32'd1);
      chk("t6_data", 32'(rsp_data), 32'd0);
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      offer(10'd50, 3'd2);
      seen_i = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (root_in_valid) seen_i = 1;
      end
      chk("t6_stale_block", 32'(seen_i), 32'd0);
      chk("t6_busy", 32'(busy), 32'd1);
      late_tog = ~late_tog; root_mode = 1; root_lat = 1;
      seen_i = 0; got_i = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (root_in_valid) seen_i = 1;
         if (rsp_valid) begin got_i = 1; break; end
      end
      chk("t6_reissue", 32'(seen_i), 32'd1);
      chk("t6_rsp2", 32'(got_i), 32'd1);
      chk("t6_err2", 32'(rsp_err), 32'd0);
      chk("t6_data2", 32'(rsp_data), 32'(root_fn(10'd50, 3'd2)));
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
`endif

      // randomized traffic with random consumer stalls
      root_mode = 1; rand_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         root_lat = $urandom_range(0, 4);
         offer(10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 3)) step();
      end
      drain("rand_drain");
      rand_ready = 1'b0; rsp_ready = 1'b0;
      step();
      chk("final_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
